// File: rtl/fib_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the series controller and its register-file/ALU datapath.
interface fib_seq_ctrl_if #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 5,
  parameter int DATA_W   = 16,
  parameter int OP_W     = 8
);
  logic                start;
  logic                mode;
  logic [7:0]          count;
  logic [DATA_W-1:0]   seed;
  logic [DATA_W-1:0]   step;
  logic                hold;
  logic                alu_carry;
  logic [OP_W-1:0]     alu_op;
  logic [SEL_W-1:0]    muxA;
  logic [SEL_W-1:0]    muxB;
  logic [DATA_W-1:0]   imm;
  logic                imm_control;
  logic [NUM_REGS-1:0] regs_en;
  logic                buff_en;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [7:0]          term_idx;

  modport master (
    output start, mode, count, seed, step, hold, alu_carry,
    input  alu_op, muxA, muxB, imm, imm_control, regs_en, buff_en,
           busy, done, overflow, term_idx
  );

  modport slave (
    input  start, mode, count, seed, step, hold, alu_carry,
    output alu_op, muxA, muxB, imm, imm_control, regs_en, buff_en,
           busy, done, overflow, term_idx
  );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Control FSM sequencing the register-file/ALU datapath to build a Fibonacci or
// arithmetic series across a ring of destination registers R1..R(NUM_REGS-1).
module fib_seq_ctrl #(
  parameter int              NUM_REGS = 16,
  parameter int              SEL_W    = 5,
  parameter int              DATA_W   = 16,
  parameter int              OP_W     = 8,
  parameter logic [OP_W-1:0] OP_ADD   = 8'h05
) (
  input  logic          clk,
  input  logic          reset,
  fib_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [7:0]          count_q, count_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [DATA_W-1:0]   step_q, step_d;
  logic [SEL_W-1:0]    dest_q, dest_d;
  logic [SEL_W-1:0]    destp_q, destp_d;
  logic [7:0]          term_q, term_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [SEL_W-1:0]    mux_a_q, mux_a_d;
  logic [SEL_W-1:0]    mux_b_q, mux_b_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                immc_q, immc_d;
  logic [NUM_REGS-1:0] regs_en_q, regs_en_d;
  logic                buff_q, buff_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                write_now;
  logic [SEL_W-1:0]    dest_next;

  assign write_now = (state_q == S_RUN) && (regs_en_q != '0);
  assign dest_next = (dest_q == SEL_W'(NUM_REGS - 1)) ? SEL_W'(1) : dest_q + SEL_W'(1);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    count_d   = count_q;
    seed_d    = seed_q;
    step_d    = step_q;
    dest_d    = dest_q;
    destp_d   = destp_q;
    term_d    = term_q;
    mux_a_d   = mux_a_q;
    mux_b_d   = mux_b_q;
    imm_d     = imm_q;
    immc_d    = immc_q;
    regs_en_d = '0;
    alu_op_d  = '0;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          count_d = bus.count;
          seed_d  = bus.seed;
          step_d  = bus.step;
          ovf_d   = 1'b0;
          term_d  = 8'd1;
          if (bus.count == 8'd0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RUN;
            dest_d    = SEL_W'(1);
            destp_d   = '0;
            mux_a_d   = '0;
            mux_b_d   = '0;
            imm_d     = bus.seed;
            immc_d    = 1'b1;
            regs_en_d = NUM_REGS'(1) << dest_d;
            alu_op_d  = OP_ADD;
          end
        end
      end

      S_RUN: begin
        if (write_now && bus.alu_carry) ovf_d = 1'b1;
        if (write_now && (bus.alu_carry || term_q == count_q)) begin
          state_d = S_DONE;
          mux_a_d = '0;
          mux_b_d = '0;
          imm_d   = '0;
          immc_d  = 1'b0;
        end else begin
          // Operands are only recomputed once the current term has actually
          // been written; a held term is simply re-presented.
          if (write_now) begin
            term_d  = term_q + 8'd1;
            dest_d  = dest_next;
            destp_d = dest_q;
            if (mode_q) begin
              mux_a_d = dest_q;
              mux_b_d = '0;
              imm_d   = step_q;
              immc_d  = 1'b1;
            end else begin
              mux_a_d = (term_q == 8'd1) ? dest_q : destp_q;
              mux_b_d = (term_q == 8'd1) ? '0 : dest_q;
              imm_d   = '0;
              immc_d  = 1'b0;
            end
          end
          if (!bus.hold) begin
            regs_en_d = NUM_REGS'(1) << dest_d;
            alu_op_d  = OP_ADD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    buff_d = buff_q | (regs_en_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      count_q   <= '0;
      seed_q    <= '0;
      step_q    <= '0;
      dest_q    <= '0;
      destp_q   <= '0;
      term_q    <= '0;
      alu_op_q  <= '0;
      mux_a_q   <= '0;
      mux_b_q   <= '0;
      imm_q     <= '0;
      immc_q    <= 1'b0;
      regs_en_q <= '0;
      buff_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      seed_q    <= seed_d;
      step_q    <= step_d;
      dest_q    <= dest_d;
      destp_q   <= destp_d;
      term_q    <= term_d;
      alu_op_q  <= alu_op_d;
      mux_a_q   <= mux_a_d;
      mux_b_q   <= mux_b_d;
      imm_q     <= imm_d;
      immc_q    <= immc_d;
      regs_en_q <= regs_en_d;
      buff_q    <= buff_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.alu_op      = alu_op_q;
  assign bus.muxA        = mux_a_q;
  assign bus.muxB        = mux_b_q;
  assign bus.imm         = imm_q;
  assign bus.imm_control = immc_q;
  assign bus.regs_en     = regs_en_q;
  assign bus.buff_en     = buff_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.overflow    = ovf_q;
  assign bus.term_idx    = term_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: attaches a register file + adder model and
// compares every cycle against series values computed directly from the term rules.
module tb_fib_seq_ctrl;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   force_k = 0;
  bit   buff_exp = 0;
  int   vals [0:300];
  bit   cy   [0:300];

  logic [15:0] rf [0:31] = '{default: '0};
  logic [16:0] alu_sum;

  fib_seq_ctrl_if #(.NUM_REGS(NR), .SEL_W(5), .DATA_W(16), .OP_W(8)) bus ();

  fib_seq_ctrl #(.NUM_REGS(NR), .SEL_W(5), .DATA_W(16), .OP_W(8), .OP_ADD(8'h05)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign alu_sum = {1'b0, rf[bus.muxA]} + {1'b0, (bus.imm_control ? bus.imm : rf[bus.muxB])};
  assign bus.alu_carry = alu_sum[16] | ((force_k != 0) && (int'(bus.term_idx) == force_k));

  always @(posedge clk)
    for (int i = 1; i < NR; i++)
      if (bus.regs_en[i]) rf[i] <= alu_sum[15:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dest(input int k);
    return 1 + ((k - 1) % (NR - 1));
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_regs_en"}, 32'(bus.regs_en), 0);
    chk({tag, "_alu_op"}, 32'(bus.alu_op), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_buff_en"}, 32'(bus.buff_en), 32'(buff_exp));
  endtask

  task automatic run(input bit m, input int cnt, input logic [15:0] sd, input logic [15:0] stp,
                     input int fk, input int hk, input int hl, input int hpct, input bit noise);
    int k, nk, hold_left, guard, ea, eb, ei, ec;
    bit wr, ended, ovf, hold_done;
    vals[1] = int'(sd);
    cy[1]   = 1'b0;
    for (int i = 2; i <= cnt; i++) begin
      int s;
      if (m)           s = vals[i-1] + int'(stp);
      else if (i == 2) s = int'(sd);
      else             s = vals[i-1] + vals[i-2];
      cy[i]   = (s > 'hFFFF);
      vals[i] = s & 'hFFFF;
    end
    force_k   = fk;
    bus.mode  = m;
    bus.count = 8'(cnt);
    bus.seed  = sd;
    bus.step  = stp;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = ~m;
    bus.count = 8'($urandom);
    bus.seed  = 16'($urandom);
    bus.step  = 16'($urandom);
    if (cnt == 0) begin
      k = 1;
      ovf = 1'b0;
    end else begin
      k = 1; wr = 1'b1; ovf = 1'b0; hold_left = 0; hold_done = 1'b0; guard = 0; ended = 1'b0;
      while (!ended) begin
        if (k == 1)  begin ea = 0; eb = 0; ei = int'(sd); ec = 1; end
        else if (m)  begin ea = dest(k-1); eb = 0; ei = int'(stp); ec = 1; end
        else if (k == 2) begin ea = dest(1); eb = 0; ei = 0; ec = 0; end
        else         begin ea = dest(k-2); eb = dest(k-1); ei = 0; ec = 0; end
        chk("run_busy", 32'(bus.busy), 1);
        chk("run_done", 32'(bus.done), 0);
        chk("run_term_idx", 32'(bus.term_idx), k);
        chk("run_overflow", 32'(bus.overflow), 0);
        chk("run_muxA", 32'(bus.muxA), ea);
        chk("run_muxB", 32'(bus.muxB), eb);
        chk("run_imm", 32'(bus.imm), ei);
        chk("run_imm_control", 32'(bus.imm_control), ec);
        chk("run_regs_en", 32'(bus.regs_en), wr ? (32'd1 << dest(k)) : 32'd0);
        chk("run_alu_op", 32'(bus.alu_op), wr ? 32'h05 : 32'h00);
        if (wr) begin
          buff_exp = 1'b1;
          chk("alu_result", 32'(alu_sum[15:0]), vals[k]);
        end
        chk("run_buff_en", 32'(bus.buff_en), 32'(buff_exp));
        ended = wr && (cy[k] || k == fk || k == cnt);
        if (ended) ovf = cy[k] || (k == fk);
        nk = wr ? k + 1 : k;
        if (nk == hk && !hold_done) begin hold_left = hl; hold_done = 1'b1; end
        bus.hold = (hold_left > 0) || ($urandom_range(0, 99) < hpct);
        if (hold_left > 0) hold_left--;
        bus.start = noise && ($urandom_range(0, 3) == 0);
        if (!ended) begin k = nk; wr = !bus.hold; end
        guard++;
        if (guard > 2000) begin
          total++; bad++;
          $error("FAIL run_bound observed=%0d cycles expected=done", guard);
          ended = 1'b1;
        end
        @(negedge clk);
      end
      bus.hold  = 1'b0;
      bus.start = 1'b0;
    end
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_term_idx", 32'(bus.term_idx), k);
    chk("done_overflow", 32'(bus.overflow), 32'(ovf));
    chk("done_muxA", 32'(bus.muxA), 0);
    chk("done_muxB", 32'(bus.muxB), 0);
    chk("done_imm", 32'(bus.imm), 0);
    chk("done_imm_control", 32'(bus.imm_control), 0);
    chk_quiet("done");
    @(negedge clk);
    chk("idle_done", 32'(bus.done), 0);
    chk("idle_term_idx", 32'(bus.term_idx), k);
    chk("idle_overflow", 32'(bus.overflow), 32'(ovf));
    chk_quiet("idle");
    force_k = 0;
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.count = '0; bus.seed = '0; bus.step = '0; bus.hold = 1'b0;
    #2;
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_term_idx", 32'(bus.term_idx), 0);
    chk("rst_muxA", 32'(bus.muxA), 0);
    chk("rst_imm", 32'(bus.imm), 0);
    chk_quiet("rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run(0, 0, 16'd5, 16'd0, 0, 0, 0, 0, 0);          // count=0: no writes, buff_en stays 0
    run(0, 6, 16'd1, 16'd0, 0, 0, 0, 0, 0);          // 1,1,2,3,5,8
    run(1, 4, 16'd3, 16'd4, 0, 0, 0, 0, 0);          // 3,7,11,15
    run(0, 17, 16'd1, 16'd0, 0, 0, 0, 0, 0);         // ring wrap
    run(0, 10, 16'd1, 16'd0, 5, 0, 0, 0, 0);         // forced carry on term 5
    run(0, 6, 16'd2, 16'd0, 0, 3, 3, 0, 0);          // hold 3 cycles on term 3
    run(1, 12, 16'd100, 16'd7, 0, 0, 0, 20, 1);      // start pulses while busy

    bus.mode = 1'b0; bus.count = 8'd20; bus.seed = 16'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    buff_exp = 1'b0;
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_overflow", 32'(bus.overflow), 0);
    chk("arst_term_idx", 32'(bus.term_idx), 0);
    chk("arst_muxA", 32'(bus.muxA), 0);
    chk("arst_muxB", 32'(bus.muxB), 0);
    chk("arst_imm", 32'(bus.imm), 0);
    chk("arst_imm_control", 32'(bus.imm_control), 0);
    chk_quiet("arst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(bus.done), 0);
    chk_quiet("post_rst");
    run(1, 0, 16'd9, 16'd1, 0, 0, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      int c, f;
      c = int'($urandom_range(1, 40));
      f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, c)) : 0;
      run(1'($urandom), c, 16'($urandom), 16'($urandom_range(0, 3000)),
          f, int'($urandom_range(1, c)), int'($urandom_range(0, 3)), 25, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
